// File: rtl/writeback_stage.sv
// writeback_stage: retires instructions into the register-file write port,
// holding loads until the data-memory response; WB_PERF_EN adds a stall counter.
module writeback_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic        m_we,
    input  logic [4:0]  m_rd,
    input  logic        m_is_load,
    input  logic [2:0]  m_funct3,
    input  logic [1:0]  m_addr_lo,
    input  logic [31:0] m_result,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        RegWE_W,
    output logic [4:0]  A4,
    output logic [31:0] WD4,
    output logic        wb_err,
    output logic [1:0]  wb_err_code
`ifdef WB_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles
`endif
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  cnt;
    logic [4:0]  ld_rd;
    logic        ld_we;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_lo;
    logic [1:0]  ld_err;
    logic        accept;
    logic        timeout;
    logic [1:0]  acc_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;

    assign m_ready = (state == IDLE);
    assign accept  = m_valid && m_ready;
    assign timeout = (cnt == LIMIT);

    // State register; reset abandons any outstanding load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state: loads park in WAIT until response or timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept && m_is_load) next_state = WAIT;
            WAIT: if (mem_rvalid || timeout) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Classify a load at accept: misaligned (10) or illegal funct3 (11).
    always_comb begin
        acc_err = 2'b00;
        case (m_funct3)
            3'b001, 3'b101: if (m_addr_lo[0]) acc_err = 2'b10;
            3'b010:         if (m_addr_lo != 2'b00) acc_err = 2'b10;
            3'b011, 3'b110, 3'b111: acc_err = 2'b11;
            default: acc_err = 2'b00;
        endcase
    end

    // Lane selection and sign/zero extension of the response word.
    always_comb begin
        byte_sel = mem_rdata[{ld_lo, 3'b000} +: 8];
        half_sel = mem_rdata[{ld_lo[1], 4'b0000} +: 16];
        case (ld_f3)
            3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ld_data = {24'b0, byte_sel};
            3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ld_data = {16'b0, half_sel};
            default: ld_data = mem_rdata;
        endcase
    end

    // Write port, load context, timeout counter and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWE_W     <= 1'b0;
            A4          <= 5'd0;
            WD4         <= 32'd0;
            wb_err      <= 1'b0;
            wb_err_code <= 2'b00;
            cnt         <= 8'd0;
            ld_rd       <= 5'd0;
            ld_we       <= 1'b0;
            ld_f3       <= 3'd0;
            ld_lo       <= 2'd0;
            ld_err      <= 2'b00;
        end else begin
            RegWE_W <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && m_is_load) begin
                        ld_rd  <= m_rd;
                        ld_we  <= m_we;
                        ld_f3  <= m_funct3;
                        ld_lo  <= m_addr_lo;
                        ld_err <= acc_err;
                        cnt    <= 8'd0;
                    end else if (accept) begin
                        RegWE_W <= m_we && (m_rd != 5'd0);
                        A4      <= m_rd;
                        WD4     <= m_result;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (ld_err == 2'b00) begin
                            RegWE_W <= ld_we && (ld_rd != 5'd0);
                            A4      <= ld_rd;
                            WD4     <= ld_data;
                        end else begin
                            wb_err <= 1'b1;
                            if (!wb_err) wb_err_code <= ld_err;
                        end
                    end else if (timeout) begin
                        wb_err <= 1'b1;
                        if (!wb_err) wb_err_code <= 2'b01;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WB_PERF_EN
    // Saturating count of cycles the memory stage is held off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_stall_cycles <= 32'd0;
        else if (m_valid && !m_ready && (perf_stall_cycles != 32'hFFFF_FFFF))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed plus randomized checks of writeback_stage
// against an arithmetic reference model of load extension and error rules.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic        m_ready;
    logic        m_we;
    logic [4:0]  m_rd;
    logic        m_is_load;
    logic [2:0]  m_funct3;
    logic [1:0]  m_addr_lo;
    logic [31:0] m_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        RegWE_W;
    logic [4:0]  A4;
    logic [31:0] WD4;
    logic        wb_err;
    logic [1:0]  wb_err_code;

    int passed = 0;
    int total  = 0;

    writeback_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_we(m_we), .m_rd(m_rd), .m_is_load(m_is_load),
        .m_funct3(m_funct3), .m_addr_lo(m_addr_lo), .m_result(m_result),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .RegWE_W(RegWE_W), .A4(A4), .WD4(WD4),
        .wb_err(wb_err), .wb_err_code(wb_err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: pick lane by shifting, extend by adding the sign fill.
    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (int'(lo) * 8)) % 256;
        h = (w >> (int'(lo[1]) * 16)) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic int ref_err(input logic [2:0] f3, input logic [1:0] lo);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 3;
        if ((f3 == 1 || f3 == 5) && (lo % 2 == 1)) return 2;
        if (f3 == 2 && lo != 0) return 2;
        return 0;
    endfunction

    task automatic alu(input logic [4:0] rd, input logic we,
                       input logic [31:0] res);
        m_valid = 1; m_is_load = 0; m_rd = rd; m_we = we; m_result = res;
        m_funct3 = 3'($urandom); m_addr_lo = 2'($urandom);
        tick;
        check("alu_we", RegWE_W, we && rd != 0);
        check("alu_a4", A4, rd);
        check("alu_wd", WD4, res);
        check("alu_ready", m_ready, 1);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [1:0] lo,
                           input logic [4:0] rd, input logic we,
                           input int delay, input logic [31:0] rdata);
        int code;
        logic exp_we;
        code = ref_err(f3, lo);
        m_valid = 1; m_is_load = 1; m_funct3 = f3; m_addr_lo = lo;
        m_rd = rd; m_we = we; m_result = $urandom;
        tick;
        m_valid = 0; m_is_load = 0;
        check("ld_ready_low", m_ready, 0);
        check("ld_accept_nowe", RegWE_W, 0);
        for (int i = 1; i < delay; i++) begin
            tick;
            check("ld_wait_ready", m_ready, 0);
            check("ld_wait_nowe", RegWE_W, 0);
        end
        mem_rvalid = 1; mem_rdata = rdata;
        tick;
        mem_rvalid = 0; mem_rdata = $urandom;
        exp_we = we && rd != 0 && code == 0;
        check("ld_we", RegWE_W, exp_we);
        if (exp_we) begin
            check("ld_a4", A4, rd);
            check("ld_wd", WD4, ref_load(f3, lo, rdata));
        end
        if (code != 0) check("ld_err", wb_err, 1);
        check("ld_ready_back", m_ready, 1);
        tick;
        check("ld_pulse_end", RegWE_W, 0);
    endtask

    task automatic do_reset;
        reset = 1;
        tick;
        tick;
        reset = 0;
    endtask

    initial begin
        int cyc;
        logic saw_we;
        logic [2:0] f3;
        logic [1:0] lo;
        reset = 1; m_valid = 0; m_we = 0; m_rd = 0; m_is_load = 0;
        m_funct3 = 0; m_addr_lo = 0; m_result = 0;
        mem_rvalid = 0; mem_rdata = 0;
        #1;
        check("rst_we", RegWE_W, 0);
        check("rst_a4", A4, 0);
        check("rst_wd", WD4, 0);
        check("rst_err", wb_err, 0);
        check("rst_code", wb_err_code, 0);
        check("rst_ready", m_ready, 1);
        do_reset;

        alu(5'd5, 1, 32'hDEAD_BEEF);
        m_valid = 0;
        tick;
        check("alu_pulse_end", RegWE_W, 0);

        alu(5'd0, 1, 32'h0000_1234);
        alu(5'd7, 1, 32'h0000_0001);
        m_valid = 0;
        tick;

        do_load(3'd0, 2'd2, 5'd9, 1, 3, 32'h1280_FF00);
        do_load(3'd5, 2'd2, 5'd10, 1, 2, 32'h8001_0000);
        mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        tick;
        mem_rvalid = 0;
        check("idle_rvalid_ignored", RegWE_W, 0);
        check("idle_rvalid_ready", m_ready, 1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1, 0) == 0) begin
                alu(5'($urandom), 1'($urandom), $urandom);
                m_valid = 0;
            end else begin
                case ($urandom_range(4, 0))
                    0: begin f3 = 3'd0; lo = 2'($urandom); end
                    1: begin f3 = 3'd4; lo = 2'($urandom); end
                    2: begin f3 = 3'd1; lo = 2'($urandom_range(1, 0) * 2); end
                    3: begin f3 = 3'd5; lo = 2'($urandom_range(1, 0) * 2); end
                    default: begin f3 = 3'd2; lo = 2'd0; end
                endcase
                do_load(f3, lo, 5'($urandom), 1'($urandom),
                        $urandom_range(10, 1), $urandom);
            end
        end
        check("no_err_after_random", wb_err, 0);

        m_valid = 1; m_is_load = 1; m_funct3 = 3'd2; m_addr_lo = 0;
        m_rd = 5'd3; m_we = 1;
        tick;
        m_valid = 0; m_is_load = 0;
        cyc = 0; saw_we = 0;
        while (!m_ready && cyc < 40) begin
            tick;
            cyc++;
            if (RegWE_W) saw_we = 1;
        end
        check("to_cycles", cyc, 16);
        check("to_nowrite", saw_we, 0);
        check("to_err", wb_err, 1);
        check("to_code", wb_err_code, 2'b01);

        do_load(3'd1, 2'd1, 5'd4, 1, 2, 32'h1234_5678);
        check("first_err_kept", wb_err_code, 2'b01);

        do_reset;
        check("rst2_err", wb_err, 0);
        do_load(3'd1, 2'd1, 5'd4, 1, 2, 32'h1234_5678);
        check("mis_code", wb_err_code, 2'b10);
        do_load(3'd6, 2'd0, 5'd6, 1, 1, 32'hCAFE_F00D);
        check("ill_keeps_code", wb_err_code, 2'b10);
        do_load(3'd2, 2'd2, 5'd8, 1, 4, 32'h0BAD_0BAD);
        check("lw_mis_code", wb_err_code, 2'b10);

        m_valid = 1; m_is_load = 1; m_funct3 = 3'd2; m_addr_lo = 0;
        m_rd = 5'd12; m_we = 1;
        tick;
        m_valid = 0; m_is_load = 0;
        tick;
        check("mid_wait_ready", m_ready, 0);
        reset = 1;
        #1;
        check("midrst_we", RegWE_W, 0);
        check("midrst_a4", A4, 0);
        check("midrst_wd", WD4, 0);
        check("midrst_err", wb_err, 0);
        check("midrst_code", wb_err_code, 0);
        check("midrst_ready", m_ready, 1);
        tick;
        reset = 0;
        mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
        tick;
        mem_rvalid = 0;
        check("late_rvalid_nowe", RegWE_W, 0);
        check("late_rvalid_ready", m_ready, 1);
        check("late_rvalid_wd", WD4, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Takes retiring instructions from the memory stage and drives the Writeback write port of the register file (RegWE_W, A4, WD4).
- Holds each load until the data-memory response arrives, then byte/half-extends the data before writing it back.
- While a load is outstanding, back-pressures the memory stage through m_ready.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of cycles spent waiting for mem_rvalid after a load is accepted; range 2..255.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- m_valid  input  1  memory stage presents an instruction
- m_ready  output  1  stage can accept this cycle
- m_we  input  1  instruction writes rd
- m_rd  input  5  destination register
- m_is_load  input  1  instruction is a load
- m_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- m_addr_lo  input  2  load address bits [1:0]
- m_result  input  32  ALU/non-load result
- mem_rvalid  input  1  data-memory read response valid
- mem_rdata  input  32  read word, aligned to its 32-bit word boundary
- RegWE_W  output  1  register-file write enable
- A4  output  5  register-file write address
- WD4  output  32  register-file write data
- wb_err  output  1  sticky error flag
- wb_err_code  output  2  01 timeout, 10 misaligned, 11 illegal funct3; first error wins

Behaviour:
- Reset (async): RegWE_W=0, A4=0, WD4=0, wb_err=0, wb_err_code=00, FSM=IDLE, timeout counter=0.
- m_ready = (state==IDLE). Combinational from state only, with no dependence on m_valid.
- Accept: a transfer occurs on any edge where m_valid && m_ready.
- Registered outputs: RegWE_W, A4 and WD4 are registered. RegWE_W is a one-cycle pulse and is 0 in every other cycle.
- FSM, IDLE:
  - Non-load accepted at edge N: RegWE_W=m_we && (m_rd!=0) and A4=m_rd, WD4=m_result take effect from edge N. Stay in IDLE, so back-to-back writes run at full throughput.
  - Load accepted: latch rd, we, funct3 and addr_lo; clear the counter; go to WAIT. RegWE_W is 0 for this edge.
- FSM, WAIT:
  - Counter increments each cycle.
  - mem_rvalid high at edge K: load the extended data into WD4, set A4=latched rd and RegWE_W=(we && rd!=0). Return to IDLE at edge K, so m_ready is high in cycle K+1.
  - Counter reaches TIMEOUT_CYCLES-1 without mem_rvalid: set the timeout error, suppress the write, return to IDLE.
  - mem_rvalid received while in IDLE is ignored.
- Load extension, with byte lane = addr_lo and half lane = addr_lo[1]:
  - LB/LBU: selected byte, sign- or zero-extended.
  - LH/LHU: selected half, sign- or zero-extended.
  - LW: full word.
- Misaligned load (LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0): detected at accept. Still enter WAIT and consume the response, then suppress the write and flag error 10.
- Illegal funct3 (011, 110, 111): handled the same way, flagged as error 11.
- x0: writes with rd=0 are never asserted on RegWE_W, although A4/WD4 may still update.
- wb_err stays set until reset. wb_err_code records only the first error.
- Reset mid-WAIT: returns to IDLE immediately; a late mem_rvalid is ignored.
- Timeout counter is 8 bits wide and never wraps, because it leaves WAIT at TIMEOUT_CYCLES-1.

Optional Feature:
- Macro WB_PERF_EN.
- Defined:
  - Adds output perf_stall_cycles (32 bits).
  - Increments on every cycle where m_valid && !m_ready; saturates at 0xFFFFFFFF.
  - Reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- ALU retire: m_valid=1, m_we=1, m_rd=5, m_result=0xDEADBEEF, single cycle -> next cycle RegWE_W=1, A4=5, WD4=0xDEADBEEF; RegWE_W=0 the following cycle.
- x0 suppression and back-to-back: rd=0 then rd=7 with 0x1 on consecutive cycles -> m_ready stays 1; RegWE_W 0 then 1; A4=7, WD4=0x1.
- Load byte: LB, addr_lo=2, mem_rvalid 3 cycles later with rdata=0x1280FF00 -> m_ready=0 while waiting; WD4=0xFFFFFF80, RegWE_W=1 once.
- LHU: addr_lo=2, rdata=0x8001_0000 -> WD4=0x00008001.
- Timeout: LW accepted, no mem_rvalid for 16 cycles -> no write, wb_err=1, wb_err_code=01, m_ready returns to 1.
- Misaligned then reset: LH with addr_lo=1 -> after response, no write, wb_err_code=10. Then assert reset while a new load is in WAIT -> all outputs 0, m_ready=1, and a late mem_rvalid causes no write.
